dm_mc_responder: RTL and testbench
==================================

Name: dm_mc_responder

Overview:
Multi-cycle data-memory responder for the multi-cycle CPU's data-memory port. It replaces the single-cycle, always-ready memory with a req/ready handshake, a programmable number of wait states, and byte-enabled writes. It flags misaligned and out-of-range accesses so the CPU-side control FSM can stall on memory and detect bad addresses.

Parameters:
ADDR_W, 7, word-index width; memory holds 2^ADDR_W 32-bit words (byte address bits [ADDR_W+1:2]).
WAIT, 2, wait states between acceptance and response (0..15).

Ports:
clk  input  1  CPU clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-high reset.
req  input  1  access request; sampled only when the block can accept.
we  input  1  1 = write, 0 = read; qualified by req.
addr  input  32  byte address; qualified by req.
be  input  4  write byte enables, be[i] -> wdata[8i+7:8i]; ignored for reads.
wdata  input  32  write data; qualified by req.
rdata  output  32  read data; valid while ready=1; held until next response.
ready  output  1  one-cycle response strobe.
err  output  1  error flag; valid with ready.
busy  output  1  1 while an accepted access is pending (state WAIT).

Behaviour:
- Reset is asynchronous and active-high. While rst=1: state=IDLE; ready=0, err=0, busy=0, rdata=0; wait counter=0. Memory array contents are not reset.
- States:
  - IDLE: ready=0, busy=0.
  - WAIT: busy=1, ready=0.
  - RESP: ready=1 for exactly one cycle, busy=0.
- Acceptance: req is accepted at a rising edge when the state is IDLE or RESP. On acceptance, we, addr, be and wdata are latched; later changes to those inputs have no effect on the access.
- req while in WAIT is ignored (not queued). The initiator must hold req until it samples ready=1, then drop or re-issue it.
- After acceptance:
  - If WAIT=0: next state is RESP.
  - Otherwise: next state is WAIT, with the counter loaded with WAIT-1.
  - In WAIT: the counter decrements each cycle; when the counter is 0, next state is RESP.
- Latency: accepted at edge k means ready is high in the cycle following edge k+WAIT (WAIT+1 edges).
- Back-to-back: a req sampled in RESP is accepted at the edge that leaves RESP. Sustained throughput is one access per WAIT+1 cycles.
- Error detection is evaluated on the latched address. err=1 if:
  - addr[1:0] != 0 (misaligned), or
  - addr[31:ADDR_W+2] != 0 (out of range).
- Memory access on the edge entering RESP:
  - Error: no write; rdata=0; err=1.
  - Write: only enabled bytes are updated; rdata = the full updated word (write-through readback); err=0.
  - Read: rdata = mem[addr[ADDR_W+1:2]]; err=0.
- Leaving RESP without a new req: next state is IDLE, ready=0; rdata and err hold their values.
- Reset mid-operation (WAIT or RESP): the access is aborted; no write if the write edge has not yet occurred; outputs return to reset values.
- be=0000 on a write is legal: memory is unchanged and a normal response is given.

Test Plan:
1. WAIT=2: reset, then write addr=0x10, be=1111, wdata=0xDEADBEEF at edge k -> busy=1 after edges k and k+1; ready=1, err=0, rdata=0xDEADBEEF after edge k+2; ready=0 next cycle.
2. Read addr=0x10 after case 1 -> ready after 3 edges, rdata=0xDEADBEEF. Then write be=0010, wdata=0x0000AA00 and read back -> rdata=0xDEADAAEF.
3. Back-to-back: keep req=1 with reads of 0x10 and 0x14 (0x14 preloaded 0x12345678) -> ready pulses 3 cycles apart, rdata=0xDEADAAEF then 0x12345678; no lost or duplicated response.
4. Errors: read addr=0x12 -> ready, err=1, rdata=0. Write addr=0x200 with ADDR_W=7 -> err=1, and word 0 is unchanged on readback.
5. Reset mid-operation: assert rst one cycle after accepting a write of 0x11111111 to 0x20 (WAIT=2) -> outputs go to 0 immediately; a later read of 0x20 returns the prior value.
6. WAIT=0 build: req held high -> ready high every cycle from the cycle after the first accept edge, one response per request, with correct data.

Source files
------------

// File: rtl/dm_mc_responder.sv
// Multi-cycle data-memory responder: req/ready handshake, programmable wait states,
// byte-enabled writes with write-through readback, misaligned/out-of-range error flag.
module dm_mc_responder #(
   parameter int ADDR_W = 7,
   parameter int WAIT   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [3:0]  be,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        err,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   localparam int          DEPTH    = 1 << ADDR_W;
   localparam logic [3:0]  CNT_LOAD = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

   state_t              r_state;
   state_t              w_next;
   logic [3:0]          r_cnt;
   logic                r_we;
   logic [31:0]         r_addr;
   logic [3:0]          r_be;
   logic [31:0]         r_wdata;
   logic [31:0]         r_rdata;
   logic                r_err;
   logic [31:0]         r_mem [0:DEPTH-1];

   logic                w_accept;
   logic                w_a_we;
   logic [31:0]         w_a_addr;
   logic [3:0]          w_a_be;
   logic [31:0]         w_a_wdata;
   logic                w_a_err;
   logic [ADDR_W-1:0]   w_idx;
   logic [31:0]         w_old;
   logic [31:0]         w_merged;
   logic                w_do_access;
   logic                w_do_write;

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      case (r_state)
         S_IDLE, S_RESP: begin
            if (req) begin
               w_accept = 1'b1;
               w_next   = (WAIT == 0) ? S_RESP : S_WAIT;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
         default: w_next = S_IDLE;
      endcase
   end

   // With WAIT=0 the access happens on the accept edge, before the latches hold the request.
   assign w_a_we    = w_accept ? we    : r_we;
   assign w_a_addr  = w_accept ? addr  : r_addr;
   assign w_a_be    = w_accept ? be    : r_be;
   assign w_a_wdata = w_accept ? wdata : r_wdata;

   assign w_a_err = (w_a_addr[1:0] != 2'b00) || (w_a_addr[31:ADDR_W+2] != '0);
   assign w_idx   = w_a_addr[ADDR_W+1:2];
   assign w_old   = r_mem[w_idx];

   always_comb begin
      for (int i = 0; i < 4; i++)
         w_merged[8*i +: 8] = w_a_be[i] ? w_a_wdata[8*i +: 8] : w_old[8*i +: 8];
   end

   assign w_do_access = (w_next == S_RESP);
   assign w_do_write  = !rst && w_do_access && w_a_we && !w_a_err;

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_we    <= 1'b0;
         r_addr  <= 32'd0;
         r_be    <= 4'd0;
         r_wdata <= 32'd0;
         r_rdata <= 32'd0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_we    <= we;
            r_addr  <= addr;
            r_be    <= be;
            r_wdata <= wdata;
            r_cnt   <= CNT_LOAD;
         end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_do_access) begin
            r_err   <= w_a_err;
            r_rdata <= w_a_err ? 32'd0 : (w_a_we ? w_merged : w_old);
         end
      end
   end

   // NOTE: the memory array has no reset; only the control path is cleared.
   always_ff @(posedge clk) begin
      if (w_do_write) r_mem[w_idx] <= w_merged;
   end

   assign rdata = r_rdata;
   assign err   = r_err;
   assign ready = (r_state == S_RESP);
   assign busy  = (r_state == S_WAIT);

endmodule

// File: tb/tb_dm_mc_responder.sv
// Scoreboard bench for dm_mc_responder: a WAIT=2 instance driven by directed and random
// handshakes, and a WAIT=0 instance driven with req held high.
module tb_dm_mc_responder;

   localparam int ADDR_W  = 7;
   localparam int WORDS   = 1 << ADDR_W;
   localparam int WAIT_TB = 2;

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } resp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req, we;
   logic [31:0] addr, wdata, rdata;
   logic [3:0]  be;
   logic        ready, err, busy;
   logic        req0, we0;
   logic [31:0] addr0, wdata0, rdata0;
   logic [3:0]  be0;
   logic        ready0, err0, busy0;

   int n_cmp = 0;
   int n_bad = 0;

   resp_t       q2[$];
   resp_t       q0[$];
   logic [31:0] mdl2 [0:WORDS-1];
   logic [31:0] mdl0 [0:WORDS-1];

   always #5 clk = ~clk;

   dm_mc_responder #(.ADDR_W(ADDR_W), .WAIT(WAIT_TB)) u_dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .be(be), .wdata(wdata),
      .rdata(rdata), .ready(ready), .err(err), .busy(busy)
   );

   dm_mc_responder #(.ADDR_W(ADDR_W), .WAIT(0)) u_dut0 (
      .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .be(be0), .wdata(wdata0),
      .rdata(rdata0), .ready(ready0), .err(err0), .busy(busy0)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: byte-addressed word memory; bad addresses give err with zero data.
   function automatic resp_t model_access(input bit sel0, input logic w, input logic [31:0] a,
                                          input logic [3:0] b, input logic [31:0] d);
      resp_t       r;
      logic [31:0] word;
      int          idx;
      r.err   = (a % 4 != 0) || (a >= 32'(4 * WORDS));
      r.rdata = 32'd0;
      if (!r.err) begin
         idx  = int'(a / 4);
         word = sel0 ? mdl0[idx] : mdl2[idx];
         if (w) begin
            for (int i = 0; i < 4; i++)
               if (b[i]) word[8*i +: 8] = d[8*i +: 8];
            if (sel0) mdl0[idx] = word;
            else      mdl2[idx] = word;
         end
         r.rdata = word;
      end
      return r;
   endfunction

   always @(negedge clk) begin : mon2
      resp_t e;
      if (!rst && ready) begin
         if (q2.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL w2_unexpected: got response rdata=%h expected none", rdata);
         end else begin
            e = q2.pop_front();
            check("w2_err", {31'd0, err}, {31'd0, e.err});
            check("w2_rdata", rdata, e.rdata);
         end
      end
   end

   always @(negedge clk) begin : mon0
      resp_t e;
      if (!rst && ready0) begin
         if (q0.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL w0_unexpected: got response rdata=%h expected none", rdata0);
         end else begin
            e = q0.pop_front();
            check("w0_err", {31'd0, err0}, {31'd0, e.err});
            check("w0_rdata", rdata0, e.rdata);
         end
      end
   end

   // Starts at #1 after an edge; returns #1 after the edge that raised ready.
   task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d);
      int edges = 0;
      q2.push_back(model_access(1'b0, w, a, b, d));
      req = 1'b1; we = w; addr = a; be = b; wdata = d;
      do begin
         @(posedge clk); #1;
         edges++;
         if (edges == 1) begin
            we = $urandom_range(0, 1); addr = $urandom; be = 4'($urandom); wdata = $urandom;
         end
         if (!ready) check("w2_busy", {31'd0, busy}, 32'd1);
      end while (!ready && edges < 20);
      check("w2_latency", edges, WAIT_TB + 1);
   endtask

   task automatic idle(input int n);
      req = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [31:0] a, d;
      logic [3:0]  b;
      logic        w;
      rst = 1'b1;
      req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
      req0 = 1'b0; we0 = 1'b0; addr0 = '0; be0 = '0; wdata0 = '0;
      for (int i = 0; i < WORDS; i++) begin mdl2[i] = 'x; mdl0[i] = 'x; end
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", {31'd0, ready}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_ready0", {31'd0, ready0}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic write, read, partial write.
      issue(1'b1, 32'h10, 4'b1111, 32'hDEADBEEF);
      idle(1);
      check("w2_ready_drop", {31'd0, ready}, 32'd0);
      issue(1'b0, 32'h10, 4'b0000, 32'h0);
      issue(1'b1, 32'h10, 4'b0010, 32'h0000AA00);
      idle(1);
      issue(1'b0, 32'h10, 4'b0000, 32'h0);
      idle(2);

      // Back-to-back reads, be=0000 write, preload word 0 and 0x20.
      issue(1'b1, 32'h14, 4'b1111, 32'h12345678);
      issue(1'b1, 32'h00, 4'b1111, 32'h0BADF00D);
      issue(1'b1, 32'h20, 4'b1111, 32'h55AA55AA);
      idle(1);
      issue(1'b0, 32'h10, 4'b0000, 32'h0);
      issue(1'b0, 32'h14, 4'b0000, 32'h0);
      issue(1'b1, 32'h14, 4'b0000, 32'hFFFFFFFF);
      issue(1'b0, 32'h14, 4'b0000, 32'h0);
      idle(2);

      // Errors: misaligned read, out-of-range write, word 0 untouched.
      issue(1'b0, 32'h12, 4'b0000, 32'h0);
      issue(1'b1, 32'h200, 4'b1111, 32'hCAFECAFE);
      issue(1'b0, 32'h00, 4'b0000, 32'h0);
      idle(2);

      // Reset one cycle after accepting a write: outputs clear at once, no write.
      req = 1'b1; we = 1'b1; addr = 32'h20; be = 4'b1111; wdata = 32'h11111111;
      @(posedge clk); #1;
      req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("mid_rst_ready", {31'd0, ready}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_err", {31'd0, err}, 32'd0);
      check("mid_rst_rdata", rdata, 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      issue(1'b0, 32'h20, 4'b0000, 32'h0);
      idle(1);

      // Random: fill memory, then mixed traffic with occasional bad addresses.
      for (int i = 0; i < WORDS; i++) begin
         issue(1'b1, 32'(4 * i), 4'b1111, $urandom);
         if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
      end
      for (int n = 0; n < 300; n++) begin
         w = 1'($urandom_range(0, 1));
         a = 32'(4 * $urandom_range(0, WORDS - 1));
         case ($urandom_range(0, 9))
            0:       a = a + 32'($urandom_range(1, 3));
            1:       a = a | (32'd1 << $urandom_range(ADDR_W + 2, 31));
            default: ;
         endcase
         b = 4'($urandom);
         d = $urandom;
         issue(w, a, b, d);
         if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
      end
      idle(3);

      // WAIT=0: req held high, one new request every cycle.
      for (int n = 0; n < 80; n++) begin
         if (n < 16) begin
            w = 1'b1; a = 32'(4 * n); b = 4'b1111;
         end else begin
            w = 1'($urandom_range(0, 1));
            a = 32'(4 * $urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) a = a | 32'h400;
            b = 4'($urandom);
         end
         d = $urandom;
         q0.push_back(model_access(1'b1, w, a, b, d));
         req0 = 1'b1; we0 = w; addr0 = a; be0 = b; wdata0 = d;
         @(posedge clk); #1;
         check("w0_ready", {31'd0, ready0}, 32'd1);
         check("w0_busy", {31'd0, busy0}, 32'd0);
      end
      req0 = 1'b0;
      @(posedge clk); #1;
      check("w0_ready_drop", {31'd0, ready0}, 32'd0);
      idle(2);

      check("w2_queue_empty", q2.size(), 32'd0);
      check("w0_queue_empty", q0.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
